// File: rtl/mod_counter_pkg.sv
// Shared definitions for the mod-N counter and its sequence checker:
// FSM state encodings and the wrapped-increment helper.
package mod_counter_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_SYNC  = 2'd0;
   localparam state_t ST_TRACK = 2'd1;
   localparam state_t ST_ERROR = 2'd2;

   // Wrapped increment: value+1, returning to 0 after n-1.
   function automatic logic [31:0] next_mod(input logic [31:0] value, input logic [31:0] n);
      logic [31:0] result_s;
      if (value == (n - 32'd1)) begin
         result_s = 32'd0;
      end else begin
         result_s = value + 32'd1;
      end
      return result_s;
   endfunction

endpackage

// File: rtl/mod_next_val.sv
// Combinational next-value generator: the value a healthy mod-N counter
// shows one cycle after q.
module mod_next_val
   import mod_counter_pkg::*;
#(
   parameter int N = 4,
   parameter int W = 4
) (
   input  logic [W-1:0] q,
   output logic [W-1:0] nxt
);

   logic [31:0] wide_s;

   assign wide_s = next_mod(32'(q), 32'(N));
   assign nxt    = wide_s[W-1:0];

endmodule

// File: rtl/mod_seq_checker.sv
// Sequence monitor for a mod-N counter: tracks 0..N-1 wrap order, counts
// legal wraps and latches the first illegal transition in sticky registers.
module mod_seq_checker
   import mod_counter_pkg::*;
#(
   parameter int N      = 4,
   parameter int W      = 4,
   parameter int WRAP_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic [W-1:0]      q_in,
   output logic              wrap_pulse,
   output logic [WRAP_W-1:0] wrap_cnt,
   output logic              err,
   output logic [W-1:0]      err_q,
   output logic [W-1:0]      err_exp,
   output logic              synced
);

   if ((N < 1) || ((2 ** W) < N)) begin : g_bad_params
      $error("mod_seq_checker: illegal parameters, need N >= 1 and 2**W >= N");
   end

   localparam logic [W:0]   N_EXT = (W+1)'(N);
   localparam logic [W-1:0] LAST  = W'(N - 1);

   state_t       state_r;
   logic [W-1:0] q_prev_r;
   logic [W-1:0] exp_s;
   logic         in_range_s;

   mod_next_val #(.N(N), .W(W)) u_next (
      .q   (q_prev_r),
      .nxt (exp_s)
   );

   assign in_range_s = ({1'b0, q_in} < N_EXT);

   // FSM, wrap counter and sticky error capture; rst and clr both restart monitoring.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         state_r    <= ST_SYNC;
         q_prev_r   <= '0;
         wrap_pulse <= 1'b0;
         wrap_cnt   <= '0;
         err        <= 1'b0;
         err_q      <= '0;
         err_exp    <= '0;
         synced     <= 1'b0;
      end else begin
         case (state_r)
            ST_SYNC: begin
               wrap_pulse <= 1'b0;
               if (in_range_s) begin
                  q_prev_r <= q_in;
                  state_r  <= ST_TRACK;
                  synced   <= 1'b1;
               end else begin
                  state_r <= ST_ERROR;
                  err     <= 1'b1;
                  err_q   <= q_in;
                  err_exp <= '0;
                  synced  <= 1'b0;
               end
            end
            ST_TRACK: begin
               if (q_in == exp_s) begin
                  q_prev_r <= q_in;
                  if (q_prev_r == LAST) begin
                     wrap_pulse <= 1'b1;
                     wrap_cnt   <= wrap_cnt + WRAP_W'(1);
                  end else begin
                     wrap_pulse <= 1'b0;
                  end
               end else begin
                  // Covers hold, skip, backward step and out-of-range values alike.
                  state_r    <= ST_ERROR;
                  wrap_pulse <= 1'b0;
                  err        <= 1'b1;
                  err_q      <= q_in;
                  err_exp    <= exp_s;
                  synced     <= 1'b0;
               end
            end
            ST_ERROR: begin
               wrap_pulse <= 1'b0;
            end
            default: begin
               state_r    <= ST_SYNC;
               wrap_pulse <= 1'b0;
               synced     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mod_seq_checker.sv
// Directed bench for mod_seq_checker (N=4): main instance with an 8-bit wrap
// counter plus a 2-bit wrap-counter instance sharing the same stimulus.
module tb_mod_seq_checker;

   logic       clk;
   logic       rst;
   logic       clr;
   logic [3:0] q_in;

   logic       wrap_pulse;
   logic [7:0] wrap_cnt;
   logic       err;
   logic [3:0] err_q;
   logic [3:0] err_exp;
   logic       synced;

   logic       wrap_pulse2;
   logic [1:0] wrap_cnt2;
   logic       err2;
   logic [3:0] err_q2;
   logic [3:0] err_exp2;
   logic       synced2;

   int vectors;
   int miscompares;

   mod_seq_checker #(.N(4), .W(4), .WRAP_W(8)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr),
      .q_in       (q_in),
      .wrap_pulse (wrap_pulse),
      .wrap_cnt   (wrap_cnt),
      .err        (err),
      .err_q      (err_q),
      .err_exp    (err_exp),
      .synced     (synced)
   );

   mod_seq_checker #(.N(4), .W(4), .WRAP_W(2)) u_dut2 (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr),
      .q_in       (q_in),
      .wrap_pulse (wrap_pulse2),
      .wrap_cnt   (wrap_cnt2),
      .err        (err2),
      .err_q      (err_q2),
      .err_exp    (err_exp2),
      .synced     (synced2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input logic [3:0] q, input logic r, input logic c);
      q_in = q;
      rst  = r;
      clr  = c;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic p, input logic [7:0] cnt,
                            input logic e, input logic [3:0] eq, input logic [3:0] ee,
                            input logic s);
      check({tag, ".wrap_pulse"}, 32'(wrap_pulse), 32'(p));
      check({tag, ".wrap_cnt"},   32'(wrap_cnt),   32'(cnt));
      check({tag, ".err"},        32'(err),        32'(e));
      check({tag, ".err_q"},      32'(err_q),      32'(eq));
      check({tag, ".err_exp"},    32'(err_exp),    32'(ee));
      check({tag, ".synced"},     32'(synced),     32'(s));
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst  = 1'b1;
      clr  = 1'b0;
      q_in = 4'd0;

      // Reset state
      step(4'd9, 1'b1, 1'b0);
      check_all("reset", 1'b0, 8'd0, 1'b0, 4'd0, 4'd0, 1'b0);
      check("reset.wrap_cnt2", 32'(wrap_cnt2), 32'd0);

      // Healthy counter for 20 samples; wraps at samples 4, 8, 12, 16
      for (int i = 0; i < 20; i++) begin
         step(4'(i % 4), 1'b0, 1'b0);
         check_all($sformatf("run%0d", i), ((i % 4) == 0) && (i > 0), 8'(i / 4),
                   1'b0, 4'd0, 4'd0, 1'b1);
         check($sformatf("run%0d.wrap_cnt2", i), 32'(wrap_cnt2), 32'((i / 4) % 4));
         check($sformatf("run%0d.err2", i), 32'(err2), 32'd0);
      end

      // Skip 1 -> 3 after one wrap; error state then freezes everything
      step(4'd0, 1'b1, 1'b0);
      step(4'd0, 1'b0, 1'b0);
      step(4'd1, 1'b0, 1'b0);
      step(4'd2, 1'b0, 1'b0);
      step(4'd3, 1'b0, 1'b0);
      step(4'd0, 1'b0, 1'b0);
      check_all("wrap_before_skip", 1'b1, 8'd1, 1'b0, 4'd0, 4'd0, 1'b1);
      step(4'd1, 1'b0, 1'b0);
      step(4'd3, 1'b0, 1'b0);
      check_all("skip", 1'b0, 8'd1, 1'b1, 4'd3, 4'd2, 1'b0);
      step(4'd0, 1'b0, 1'b0);
      step(4'd1, 1'b0, 1'b0);
      step(4'd2, 1'b0, 1'b0);
      step(4'd3, 1'b0, 1'b0);
      check_all("frozen3", 1'b0, 8'd1, 1'b1, 4'd3, 4'd2, 1'b0);
      step(4'd0, 1'b0, 1'b0);
      check_all("frozen_wrap", 1'b0, 8'd1, 1'b1, 4'd3, 4'd2, 1'b0);

      // clr restarts; q_in at the clr edge is not checked
      step(4'd7, 1'b0, 1'b1);
      check_all("clr", 1'b0, 8'd0, 1'b0, 4'd0, 4'd0, 1'b0);
      step(4'd2, 1'b0, 1'b0);
      check_all("clr_sync2", 1'b0, 8'd0, 1'b0, 4'd0, 4'd0, 1'b1);
      step(4'd3, 1'b0, 1'b0);
      check_all("clr_3", 1'b0, 8'd0, 1'b0, 4'd0, 4'd0, 1'b1);
      step(4'd0, 1'b0, 1'b0);
      check_all("clr_wrap", 1'b1, 8'd1, 1'b0, 4'd0, 4'd0, 1'b1);

      // Hold 2 -> 2
      step(4'd1, 1'b0, 1'b0);
      check_all("hold_1", 1'b0, 8'd1, 1'b0, 4'd0, 4'd0, 1'b1);
      step(4'd2, 1'b0, 1'b0);
      step(4'd2, 1'b0, 1'b0);
      check_all("hold", 1'b0, 8'd1, 1'b1, 4'd2, 4'd3, 1'b0);

      // Out-of-range value while tracking
      step(4'd0, 1'b0, 1'b1);
      step(4'd0, 1'b0, 1'b0);
      step(4'd1, 1'b0, 1'b0);
      step(4'd4, 1'b0, 1'b0);
      check_all("track_oor", 1'b0, 8'd0, 1'b1, 4'd4, 4'd2, 1'b0);

      // Backward step
      step(4'd0, 1'b1, 1'b0);
      step(4'd2, 1'b0, 1'b0);
      step(4'd3, 1'b0, 1'b0);
      step(4'd2, 1'b0, 1'b0);
      check_all("backward", 1'b0, 8'd0, 1'b1, 4'd2, 4'd0, 1'b0);

      // Out-of-range first sample in SYNC
      step(4'd0, 1'b1, 1'b0);
      step(4'd5, 1'b0, 1'b0);
      check_all("sync_oor", 1'b0, 8'd0, 1'b1, 4'd5, 4'd0, 1'b0);

      // rst and clr together while in ERROR
      step(4'd1, 1'b1, 1'b1);
      check_all("rst_clr_err", 1'b0, 8'd0, 1'b0, 4'd0, 4'd0, 1'b0);

      // rst mid-track with q_in=2, then 0 is accepted as a fresh sync value
      step(4'd0, 1'b0, 1'b0);
      step(4'd1, 1'b0, 1'b0);
      step(4'd2, 1'b0, 1'b0);
      check_all("mid_track", 1'b0, 8'd0, 1'b0, 4'd0, 4'd0, 1'b1);
      step(4'd2, 1'b1, 1'b0);
      check_all("mid_rst", 1'b0, 8'd0, 1'b0, 4'd0, 4'd0, 1'b0);
      step(4'd0, 1'b0, 1'b0);
      check_all("resync0", 1'b0, 8'd0, 1'b0, 4'd0, 4'd0, 1'b1);
      step(4'd1, 1'b0, 1'b0);
      check_all("resync1", 1'b0, 8'd0, 1'b0, 4'd0, 4'd0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mod_seq_checker.md
Name: mod_seq_checker

Overview:
- Downstream monitor for the mod-N counter: samples the counter output `q` every clock and checks that it follows 0,1,...,N-1,0,...
- Counts wrap-arounds and pulses on each one.
- Flags the first illegal transition and holds it in sticky error registers that capture the offending and expected values.
- Used as a checker next to the counter in simulation and as a synthesizable health monitor in hardware.

Parameters:
- N, 4, counter modulus; legal values are 0..N-1.
- W, 4, width of the monitored count bus; must equal the counter's output width and satisfy 2^W >= N.
- WRAP_W, 8, width of the wrap counter.

Ports:
- clk  input  1  rising-edge clock, same clock as the counter.
- rst  input  1  synchronous, active-high reset.
- clr  input  1  synchronous clear of error and wrap state; lower priority than rst.
- q_in  input  W  count value from the mod-N counter.
- wrap_pulse  output  1  one-cycle pulse when a legal N-1 -> 0 transition is sampled.
- wrap_cnt  output  WRAP_W  number of legal wraps since reset/clr; modulo 2^WRAP_W.
- err  output  1  sticky error flag.
- err_q  output  W  q_in value that caused the first error.
- err_exp  output  W  value expected at the first error.
- synced  output  1  high while in TRACK state.

Behaviour:
- All outputs are registered. Every decision is made at the rising edge that samples q_in, and outputs reflect that decision right after the same edge (0-cycle sample-to-flag, 1-cycle flop delay).
- Internal registers:
  - q_prev (W bits): last sampled value.
  - state: SYNC / TRACK / ERROR.
- Reset (rst=1 at edge):
  - state=SYNC, q_prev=0.
  - wrap_pulse=0, wrap_cnt=0, err=0, err_q=0, err_exp=0, synced=0.
  - rst overrides clr and all other activity, including in ERROR.
- clr=1 (rst=0) at edge: same effect as reset. The value of q_in at that edge is not checked.
- expected = (q_prev == N-1) ? 0 : q_prev+1, computed in W bits. N-1 never overflows W by the parameter rule.
- SYNC:
  - If q_in < N: q_prev <= q_in, go to TRACK, synced <= 1.
  - If q_in >= N: go to ERROR, err=1, err_q=q_in, err_exp=0.
  - No wrap is counted in SYNC.
- TRACK:
  - If q_in == expected: q_prev <= q_in.
  - If additionally q_prev == N-1 (so q_in == 0): wrap_pulse=1 for this cycle and wrap_cnt <= wrap_cnt+1, rolling over to 0 at 2^WRAP_W.
  - Otherwise the transition is an error, including hold (q_in == q_prev), skip, backward step, or out-of-range q_in >= N. Then: state=ERROR, err=1, err_q=q_in, err_exp=expected, synced=0.
- ERROR:
  - Terminal until rst or clr. q_in is ignored.
  - err_q, err_exp and wrap_cnt are frozen. wrap_pulse=0.
- wrap_pulse is 0 in every cycle not described above.
- Degenerate case N=1: expected is always 0 and every TRACK sample of 0 is a wrap (wrap_pulse held high).
- Illegal parameter sets (2^W < N, N < 1) are rejected at elaboration via a generate-time error.

Decomposition:
- Shared package mod_counter_pkg holds the state enum (SYNC=2'd0, TRACK=2'd1, ERROR=2'd2) and a function next_mod(value, n) returning the wrapped increment. The counter and this checker both import it.
- One natural sub-module: mod_next_val, a combinational next-value generator parameterised by N and W, producing expected from q_prev.
- The FSM and the capture registers stay in mod_seq_checker.

Test Plan:
1. N=4. rst for 1 cycle, then drive from a live mod_counter for 20 cycles -> err=0, synced=1 from the first post-reset edge, wrap_pulse high exactly at samples where q goes 3->0, wrap_cnt=4 after the 5th 0 (wraps at samples 4,8,12,16).
2. Drive 0,1,3 -> err=1 at the edge sampling 3, err_q=3, err_exp=2, synced=0; then drive 0,1,2,3,0 -> err, err_q, err_exp and wrap_cnt unchanged, no wrap_pulse.
3. Drive 0,1,2,2 (hold) -> err=1, err_q=2, err_exp=3. Separately, out of range in SYNC: first sample 5 -> err=1, err_q=5, err_exp=0.
4. After the error of scenario 2, pulse clr for 1 cycle, then drive 2,3,0 -> err=0 and wrap_cnt=0 after clr, TRACK entered on sample 2, wrap_pulse on sample 0, wrap_cnt=1.
5. WRAP_W=2, N=4: run 4 full cycles (wraps at 4 samples) -> wrap_cnt goes 1,2,3,0 with no err.
6. Assert rst and clr together while in ERROR -> all outputs 0, state SYNC. rst asserted mid-TRACK while q_in=2 -> next sample 0 after release accepted as a sync value, no error.
